// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a one-entry skid buffer.
// The main entry drives decode; the skid entry catches the beat that arrives while decode stalls.
module if_id_skid_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int PC_STEP = 4,
    parameter int EXC_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [EXC_W-1:0]   in_exc,
    input  logic               in_bd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc4,
    output logic [PC_W-1:0]    out_pc8,
    output logic [EXC_W-1:0]   out_exc,
    output logic               out_bd
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc4;
        logic [PC_W-1:0]    pc8;
        logic [EXC_W-1:0]   exc;
        logic               bd;
    } entry_t;

    entry_t main_reg, main_next;
    entry_t skid_reg, skid_next;
    logic   main_valid_reg, main_valid_next;
    logic   skid_valid_reg, skid_valid_next;

    entry_t          beat;
    logic [PC_W-1:0] pc_plus [1:2];
    logic            accept;
    logic            consume;

    // PC+STEP and PC+2*STEP, wrapping modulo 2^PC_W.
    generate
        for (genvar gi = 1; gi <= 2; gi++) begin : g_pc_step
            assign pc_plus[gi] = in_pc + PC_W'(gi * PC_STEP);
        end
    endgenerate

    assign beat.instr = in_instr;
    assign beat.pc    = in_pc;
    assign beat.pc4   = pc_plus[1];
    assign beat.pc8   = pc_plus[2];
    assign beat.exc   = in_exc;
    assign beat.bd    = in_bd;

    assign in_ready = ~skid_valid_reg;
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid_reg & out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            // Redirect: drop everything, including the beat on offer this cycle.
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg) begin
            if (accept) begin
                main_next       = beat;
                main_valid_next = 1'b1;
            end
        end else if (consume) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next = beat;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = beat;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    // An empty stage presents an all-zero word, which decodes as sll $0,$0,0.
    assign out_valid = main_valid_reg;
    assign out_instr = main_valid_reg ? main_reg.instr : '0;
    assign out_pc    = main_reg.pc;
    assign out_pc4   = main_reg.pc4;
    assign out_pc8   = main_reg.pc8;
    assign out_exc   = main_reg.exc;
    assign out_bd    = main_reg.bd;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: accepted beats are queued with hand-computed
// expectations, and a monitor compares the stage outputs against the queue head.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_exc = '0;
    logic        in_bd = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_pc8;
    logic [4:0]  out_exc;
    logic        out_bd;

    if_id_skid_reg #(
        .INSTR_W(32), .PC_W(32), .PC_STEP(4), .EXC_W(5)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8),
        .out_exc(out_exc), .out_bd(out_bd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
    } beat_t;

    beat_t q[$];
    beat_t cur_exp;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    acc_flag = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO of depth two: head is what decode should see.
    always @(negedge reset) q.delete();

    always @(posedge clk) begin
        if (reset) begin
            bit acc, con;
            acc = in_valid && (q.size() < 2) && !flush;
            con = (q.size() > 0) && out_ready;
            acc_flag = acc;
            if (con)
                $display("[TB] consume pc=0x%08h instr=0x%08h exc=%0d bd=%0d%s",
                         q[0].pc, q[0].instr, q[0].exc, q[0].bd, flush ? " (flush)" : "");
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(cur_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
                chk("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
                chk("out_pc4", {32'd0, out_pc4}, {32'd0, q[0].pc4});
                chk("out_pc8", {32'd0, out_pc8}, {32'd0, q[0].pc8});
                chk("out_exc", {59'd0, out_exc}, {59'd0, q[0].exc});
                chk("out_bd", {63'd0, out_bd}, {63'd0, q[0].bd});
            end else begin
                chk("bubble_instr", {32'd0, out_instr}, 64'd0);
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] p4, input logic [31:0] p8,
                         input logic [4:0] exc, input bit bd, input bit ordy, input bit fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        in_exc    = exc;
        in_bd     = bd;
        out_ready = ordy;
        flush     = fl;
        cur_exp.instr = instr;
        cur_exp.pc    = pc;
        cur_exp.pc4   = p4;
        cur_exp.pc8   = p8;
        cur_exp.exc   = exc;
        cur_exp.bd    = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, ordy, 1'b0);
    endtask

    // Offer a beat until the model accepts it, within a cycle budget.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] p4, input logic [31:0] p8,
                        input logic [4:0] exc, input bit bd, input bit ordy);
        bit got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            drive(1'b1, instr, pc, p4, p8, exc, bd, ordy, 1'b0);
            got = acc_flag;
        end
        chk("accept_within_budget", {63'd0, got}, 64'd1);
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_out_pc4", {32'd0, out_pc4}, 64'd0);
        chk("rst_out_pc8", {32'd0, out_pc8}, 64'd0);
        chk("rst_out_exc", {59'd0, out_exc}, 64'd0);
        chk("rst_out_bd", {63'd0, out_bd}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Streaming at full rate.
        send(32'h2408_0001, 32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 5'd0, 1'b0, 1'b1);
        send(32'h2408_0002, 32'h0000_3004, 32'h0000_3008, 32'h0000_300C, 5'd0, 1'b0, 1'b1);
        send(32'h2408_0003, 32'h0000_3008, 32'h0000_300C, 32'h0000_3010, 5'd0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Decode stall: A in main, B in skid, C held by fetch.
        send(32'h2401_0001, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 5'd0, 1'b0, 1'b0);
        send(32'h2402_0002, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h2403_0003, 32'h0000_0108, 32'h0000_010C, 32'h0000_0110, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_c", {63'd0, acc_flag}, 64'd0);
        drive(1'b1, 32'h2403_0003, 32'h0000_0108, 32'h0000_010C, 32'h0000_0110, 5'd0, 1'b0, 1'b0, 1'b0);
        send(32'h2403_0003, 32'h0000_0108, 32'h0000_010C, 32'h0000_0110, 5'd0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Flush with both entries full and a beat on offer.
        send(32'h2404_0004, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208, 5'd0, 1'b0, 1'b0);
        send(32'h2405_0005, 32'h0000_0204, 32'h0000_0208, 32'h0000_020C, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h2406_0006, 32'h0000_0208, 32'h0000_020C, 32'h0000_0210, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_instr", {32'd0, out_instr}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1, 2);

        // PC wrap.
        send(32'h2407_0007, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 5'd0, 1'b0, 1'b1);
        idle(1'b1, 1);

        // Exception and delay-slot flag through the skid.
        send(32'h1000_0003, 32'h0000_0400, 32'h0000_0404, 32'h0000_0408, 5'd0, 1'b0, 1'b0);
        send(32'h0000_000C, 32'h0000_0404, 32'h0000_0408, 32'h0000_040C, 5'd4, 1'b1, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Asynchronous reset with two beats held.
        send(32'h2409_0009, 32'h0000_0500, 32'h0000_0504, 32'h0000_0508, 5'd0, 1'b0, 1'b0);
        send(32'h240A_000A, 32'h0000_0504, 32'h0000_0508, 32'h0000_050C, 5'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_out_instr", {32'd0, out_instr}, 64'd0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h240B_000B, 32'h0000_0600, 32'h0000_0604, 32'h0000_0608, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_accept", {63'd0, acc_flag}, 64'd1);
        chk("post_rst_latency", {63'd0, out_valid}, 64'd1);
        idle(1'b1, 3);
        chk("drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
